// File: rtl/nibble_serial_subtractor16_if.sv
// Handshake bus for the nibble-serial subtractor.
//   master: producer/consumer side (drives operands, in_valid, out_ready)
//   slave : subtractor side (drives in_ready, out_valid and the result/flags)
interface nibble_serial_subtractor16_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Diff;
    logic             Bout;
    logic             Zero;
    logic             Ovf;

    modport master (
        output in_valid, A, B, Bin, out_ready,
        input  in_ready, out_valid, Diff, Bout, Zero, Ovf
    );

    modport slave (
        input  in_valid, A, B, Bin, out_ready,
        output in_ready, out_valid, Diff, Bout, Zero, Ovf
    );
endinterface

// File: rtl/nibble_serial_subtractor16.sv
// Digit-serial subtractor: Diff = A - B - Bin, one DIGIT-bit digit per clock,
// least-significant digit first, borrow carried in a register between digits.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - slave modport: in_valid/in_ready + A/B/Bin operands,
//          out_valid/out_ready + Diff/Bout/Zero/Ovf result
module nibble_serial_subtractor16 #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    nibble_serial_subtractor16_if.slave   bus
);
    localparam int unsigned NDIG  = WIDTH / DIGIT;
    localparam int unsigned IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int unsigned SUB_W = DIGIT + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q,     state_d;
    logic [WIDTH-1:0]   a_q,         a_d;
    logic [WIDTH-1:0]   b_q,         b_d;
    logic [WIDTH-1:0]   work_q,      work_d;
    logic               borrow_q,    borrow_d;
    logic [IDX_W-1:0]   idx_q,       idx_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   diff_q,      diff_d;
    logic               bout_q,      bout_d;
    logic               zero_q,      zero_d;
    logic               ovf_q,       ovf_d;

    int unsigned        base_c;
    logic [DIGIT-1:0]   a_dig_c;
    logic [DIGIT-1:0]   b_dig_c;
    logic [SUB_W-1:0]   sub_c;

    // Next-state, digit datapath and publish logic
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        work_d      = work_q;
        borrow_d    = borrow_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        diff_d      = diff_q;
        bout_d      = bout_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;

        base_c  = 32'(idx_q) * DIGIT;
        a_dig_c = a_q[base_c +: DIGIT];
        b_dig_c = b_q[base_c +: DIGIT];
        // Extra top bit of the (DIGIT+1)-bit difference is the digit borrow-out
        sub_c   = {1'b0, a_dig_c} - {1'b0, b_dig_c} - SUB_W'(borrow_q);

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d      = bus.A;
                    b_d      = bus.B;
                    borrow_d = bus.Bin;
                    idx_d    = '0;
                    work_d   = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                work_d[base_c +: DIGIT] = sub_c[DIGIT-1:0];
                borrow_d                = sub_c[DIGIT];
                idx_d                   = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(NDIG - 1)) begin
                    // Publish using work_d so the final digit is included
                    idx_d       = '0;
                    diff_d      = work_d;
                    bout_d      = sub_c[DIGIT];
                    zero_d      = (work_d == '0);
                    ovf_d       = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                  (work_d[WIDTH-1] != a_q[WIDTH-1]);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            work_q      <= '0;
            borrow_q    <= 1'b0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            work_q      <= work_d;
            borrow_q    <= borrow_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            diff_q      <= diff_d;
            bout_q      <= bout_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
        end
    end

    // in_ready is a direct decode of the state register
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.Diff      = diff_q;
    assign bus.Bout      = bout_q;
    assign bus.Zero      = zero_q;
    assign bus.Ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_subtractor16.sv
// Directed testbench for nibble_serial_subtractor16.
module tb_nibble_serial_subtractor16;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    nibble_serial_subtractor16_if #(.WIDTH(16)) bus ();

    nibble_serial_subtractor16 #(.WIDTH(16), .DIGIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands until accepted; returns with the accept edge just passed
    task automatic do_accept(input logic [15:0] a, input logic [15:0] b, input logic bin);
        int n;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            step();
            n++;
        end
        bus.in_valid = 1'b1;
        bus.A        = a;
        bus.B        = b;
        bus.Bin      = bin;
        step();
        bus.in_valid = 1'b0;
        bus.A        = 16'hDEAD;
        bus.B        = 16'hBEEF;
        bus.Bin      = 1'b1;
    endtask

    // Count cycles after accept until out_valid is seen (bounded)
    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!bus.out_valid && cycles < 20) begin
            step();
            cycles++;
        end
    endtask

    // Consume the result with a one-cycle out_ready pulse
    task automatic consume();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.Bin       = 1'b0;
        bus.out_ready = 1'b0;
        #12;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.Diff !== 16'h0000 || bus.Bout !== 1'b0 ||
            bus.Zero !== 1'b0 || bus.Ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b d=%h bo=%b z=%b o=%b, want all zero",
                     bus.out_valid, bus.Diff, bus.Bout, bus.Zero, bus.Ovf);
        end
        rst = 1'b0;
        step();
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_basic();
        int lat;
        do_accept(16'h1234, 16'h0234, 1'b0);
        wait_valid(lat);
        n_cmp++;
        if (lat !== 4) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d want 4", lat);
        end
        n_cmp++;
        if (bus.Diff !== 16'h1000 || bus.Bout !== 1'b0 || bus.Zero !== 1'b0 || bus.Ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result: got d=%h bo=%b z=%b o=%b want d=1000 bo=0 z=0 o=0",
                     bus.Diff, bus.Bout, bus.Zero, bus.Ovf);
        end
        consume();
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_consume: got v=%b rdy=%b want v=0 rdy=1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset_mid_calc();
        int seen;
        do_accept(16'h0000, 16'h0001, 1'b0);
        step();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.Diff !== 16'h0000 || bus.Bout !== 1'b0 ||
            bus.Zero !== 1'b0 || bus.Ovf !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_calc: got v=%b d=%h bo=%b z=%b o=%b rdy=%b want 0/0000/0/0/0/1",
                     bus.out_valid, bus.Diff, bus.Bout, bus.Zero, bus.Ovf, bus.in_ready);
        end
        #1;
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.out_valid) seen++;
        end
        n_cmp++;
        if (seen !== 0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_abort: got valid_cycles=%0d rdy=%b want 0 and 1", seen, bus.in_ready);
        end
    endtask

    task automatic test_full_ripple();
        int lat;
        do_accept(16'h0000, 16'h0001, 1'b0);
        wait_valid(lat);
        n_cmp++;
        if (lat !== 4 || bus.Diff !== 16'hFFFF || bus.Bout !== 1'b1 || bus.Zero !== 1'b0 || bus.Ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL full_ripple: got lat=%0d d=%h bo=%b z=%b o=%b want 4 ffff 1 0 0",
                     lat, bus.Diff, bus.Bout, bus.Zero, bus.Ovf);
        end
        consume();
    endtask

    task automatic test_signed_ovf();
        int lat;
        do_accept(16'h8000, 16'h0001, 1'b0);
        wait_valid(lat);
        n_cmp++;
        if (lat !== 4 || bus.Diff !== 16'h7FFF || bus.Bout !== 1'b0 || bus.Zero !== 1'b0 || bus.Ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL signed_ovf: got lat=%0d d=%h bo=%b z=%b o=%b want 4 7fff 0 0 1",
                     lat, bus.Diff, bus.Bout, bus.Zero, bus.Ovf);
        end
        consume();
    endtask

    task automatic test_bin_zero();
        int lat;
        do_accept(16'h5555, 16'h5554, 1'b1);
        wait_valid(lat);
        n_cmp++;
        if (lat !== 4 || bus.Diff !== 16'h0000 || bus.Bout !== 1'b0 || bus.Zero !== 1'b1 || bus.Ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL bin_zero: got lat=%0d d=%h bo=%b z=%b o=%b want 4 0000 0 1 0",
                     lat, bus.Diff, bus.Bout, bus.Zero, bus.Ovf);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        int lat;
        int bad;
        // A5A5 - 5A5A = 4B4B; operand signs differ and result sign flips -> Ovf
        do_accept(16'hA5A5, 16'h5A5A, 1'b0);
        wait_valid(lat);
        n_cmp++;
        if (lat !== 4 || bus.Diff !== 16'h4B4B || bus.Bout !== 1'b0 || bus.Zero !== 1'b0 || bus.Ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_result: got lat=%0d d=%h bo=%b z=%b o=%b want 4 4b4b 0 0 1",
                     lat, bus.Diff, bus.Bout, bus.Zero, bus.Ovf);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = ~bus.in_valid;
            bus.A        = 16'h1111 * 16'(i);
            bus.B        = 16'hFFFF - 16'(i);
            step();
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.Diff !== 16'h4B4B ||
                bus.Bout !== 1'b0 || bus.Zero !== 1'b0 || bus.Ovf !== 1'b1) begin
                n_fail++;
                bad++;
                $display("FAIL bp_hold[%0d]: got v=%b rdy=%b d=%h bo=%b z=%b o=%b want 1 0 4b4b 0 0 1",
                         i, bus.out_valid, bus.in_ready, bus.Diff, bus.Bout, bus.Zero, bus.Ovf);
            end
        end
        bus.in_valid = 1'b0;
        consume();
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: got v=%b rdy=%b want v=0 rdy=1", bus.out_valid, bus.in_ready);
        end
        // 0100 - 0001 - 1 = 00FE
        do_accept(16'h0100, 16'h0001, 1'b1);
        wait_valid(lat);
        n_cmp++;
        if (lat !== 4 || bus.Diff !== 16'h00FE || bus.Bout !== 1'b0 || bus.Zero !== 1'b0 || bus.Ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_result: got lat=%0d d=%h bo=%b z=%b o=%b want 4 00fe 0 0 0",
                     lat, bus.Diff, bus.Bout, bus.Zero, bus.Ovf);
        end
        consume();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_basic();
        test_reset_mid_calc();
        test_full_ripple();
        test_signed_ovf();
        test_bin_zero();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/nibble_serial_subtractor16.md
# nibble_serial_subtractor16

Sequential 16-bit subtractor computing Diff = A − B − Bin one 4-bit digit per clock, least-significant digit first. The borrow between digits is carried in a register. It is the arithmetic inverse of the team's 16-bit ripple-carry adder. It serves datapaths that trade latency for a single small digit stage, and it uses valid/ready handshakes on both input and output.

## Interface
- WIDTH, 16, operand width; must be a multiple of DIGIT
- DIGIT, 4, bits processed per cycle; NDIG = WIDTH/DIGIT digit cycles
- clk  in  1  single clock, rising-edge
- rst  in  1  reset; asynchronous and active-high
- in_valid  in  1  operands presented
- in_ready  out  1  block can accept operands
- A  in  WIDTH  minuend, sampled at accept
- B  in  WIDTH  subtrahend, sampled at accept
- Bin  in  1  borrow-in, sampled at accept
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- Diff  out  WIDTH  (A − B − Bin) mod 2^WIDTH
- Bout  out  1  final borrow; 1 iff A < B + Bin (unsigned)
- Zero  out  1  Diff == 0
- Ovf  out  1  signed overflow: A[msb] != B[msb] and Diff[msb] != A[msb]

## Operation
- States are IDLE, CALC and DONE. in_ready = (state == IDLE), decoded directly from the state register.
- **IDLE**
  - On in_valid & in_ready: capture A, B and Bin into working registers, clear the digit index to 0, and load borrow with Bin.
  - Go to CALC.
- **CALC**, once per cycle for digit i:
  - {b, d} = A_i − B_i − borrow, computed as a DIGIT+1-bit subtraction.
  - Write d into work_diff[i], set borrow = b, increment i.
  - On the cycle handling i = NDIG−1, go to DONE. In that same edge, publish work_diff (including the final digit), the final borrow, and the Zero and Ovf flags into the output registers.
- **DONE**
  - out_valid = 1. Diff, Bout, Zero and Ovf stay stable.
  - On out_ready: go to IDLE and drop out_valid.
- Output registers change only at the publish edge. They hold the last result through IDLE and CALC until the next publish.
- in_valid is ignored outside IDLE. A, B and Bin may change freely after the accept edge.
- Borrow never leaks between operations; it is reloaded from Bin at every accept.

## Timing
- **Reset (asynchronous)**
  - Immediately: state = IDLE, out_valid = 0, Diff = 0, Bout = 0, Zero = 0, Ovf = 0, digit index = 0, borrow = 0.
  - in_ready = 1 once rst is low.
- **Reset mid-CALC or mid-DONE:** the operation is aborted, no out_valid is produced, and outputs read as the reset values.
- **Latency**
  - Accept at edge E0. Digits 0..NDIG−1 are processed at edges E1..E_NDIG.
  - out_valid rises after E_NDIG, i.e. 4 cycles after accept for the default parameters.
- **Throughput:** best case, with out_ready held high, is one result per NDIG+2 cycles.
  - Accept edge.
  - NDIG CALC edges.
  - DONE→IDLE handshake edge.
  - The next accept happens at the edge after in_ready returns.
- **Back-pressure:** if out_ready stays low, DONE holds indefinitely and in_ready stays 0.
- **DONE with out_ready high:**
  - The result is consumed at that edge.
  - in_ready is 1 in the next cycle.
  - No same-cycle accept-while-delivering.

## Test plan
- **Reset:** assert rst asynchronously, between edges, while in CALC. Required: out_valid = 0, Diff = 0x0000 and all flags 0 immediately; in_ready = 1 after release; no out_valid ever appears for the aborted operation.
- **Basic subtraction:** A = 0x1234, B = 0x0234, Bin = 0. Required: Diff = 0x1000, Bout = 0, Zero = 0, Ovf = 0, with out_valid exactly 4 cycles after the accept edge.
- **Full borrow ripple:** A = 0x0000, B = 0x0001, Bin = 0. Required: Diff = 0xFFFF, Bout = 1, Ovf = 0, Zero = 0.
- **Signed overflow:** A = 0x8000, B = 0x0001, Bin = 0. Required: Diff = 0x7FFF, Ovf = 1, Bout = 0.
- **Borrow-in reaching zero:** A = 0x5555, B = 0x5554, Bin = 1. Required: Diff = 0x0000, Zero = 1, Bout = 0.
- **Back-pressure:** hold out_ready low for 10 cycles in DONE while toggling in_valid, A and B. Required:
  - out_valid, Diff and flags are stable and in_ready = 0 throughout.
  - After out_ready is raised, out_valid is 0 and in_ready is 1 in the next cycle.
  - A back-to-back second operation gives the correct independent result.
